// File: rtl/ct_lsu_cb_ctrl_pkg.sv
// Shared definitions for the LSU load cache buffer (CB) controller.
//   cb_st_e  : per-entry state encoding (IDLE / PEND / VALID)
//   CB_TAG_W : tag width, PA[39:4]
package ct_lsu_cb_ctrl_pkg;
  localparam int CB_TAG_W = 36;

  typedef enum logic [1:0] {
    CB_ST_IDLE  = 2'd0,
    CB_ST_PEND  = 2'd1,
    CB_ST_VALID = 2'd2
  } cb_st_e;
endpackage

// File: rtl/ct_lsu_cb_entry.sv
// One CB entry: state FSM, physical tag, lookup/allocation tag compares and
// the dcache-index compare used for invalidation.
//   clk/rst_n  : clock, async active-low reset
//   flush      : global flush, drops the entry to IDLE
//   alloc      : this entry is the allocation victim this cycle
//   alloc_tag  : tag captured on alloc; also compared for duplicate detection
//   fill       : DA fill data good (data_vld & !ecc_cancel)
//   gwen/dc_idx: dcache write and its index (PA[11:4])
//   lkup_tag   : DC-stage lookup tag
//   vld/pend   : entry is VALID / PEND
//   dc_hit     : VALID and lookup tag matches
//   tag_match  : non-IDLE and allocation tag matches
//   inv        : dcache write hits this entry's index
//   wen        : data array write enable for this entry
module ct_lsu_cb_entry
  import ct_lsu_cb_ctrl_pkg::*;
#(
  parameter int TAG_W = CB_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             fill,
  input  logic             gwen,
  input  logic [7:0]       dc_idx,
  input  logic [TAG_W-1:0] lkup_tag,
  output logic             vld,
  output logic             pend,
  output logic             dc_hit,
  output logic             tag_match,
  output logic             inv,
  output logic             wen
);

  cb_st_e           st_q, st_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  assign vld       = (st_q == CB_ST_VALID);
  assign pend      = (st_q == CB_ST_PEND);
  assign inv       = gwen & (st_q != CB_ST_IDLE) & (tag_q[7:0] == dc_idx);
  assign wen       = pend & fill & ~flush & ~inv;
  assign dc_hit    = vld & (tag_q == lkup_tag);
  assign tag_match = (st_q != CB_ST_IDLE) & (tag_q == alloc_tag);

  // PEND always resolves in one cycle. A VALID entry being replaced takes the
  // new allocation even if its old index is invalidated in the same cycle.
  always_comb begin
    st_d  = st_q;
    tag_d = tag_q;
    if (alloc) tag_d = alloc_tag;
    if (flush) st_d = CB_ST_IDLE;
    else begin
      case (st_q)
        CB_ST_IDLE:  if (alloc) st_d = CB_ST_PEND;
        CB_ST_PEND:  st_d = wen ? CB_ST_VALID : CB_ST_IDLE;
        CB_ST_VALID: begin
          if (alloc)    st_d = CB_ST_PEND;
          else if (inv) st_d = CB_ST_IDLE;
        end
        default:     st_d = CB_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= CB_ST_IDLE;
      tag_q <= '0;
    end else begin
      st_q  <= st_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/ct_lsu_cb_ctrl.sv
// LSU load cache buffer controller. Owns entry state/tags and the
// replacement pointer; the data array is external and steered by one-hot
// cb_data_wen / cb_ld_da_rd_sel.
//   forever_cpuclk/cpurst_b : clock, async active-low reset
//   cp0_*/icc_idle          : flush sources
//   ld_dc_cb_addr_*         : DC-stage allocation request and tag
//   ld_dc_addr1             : DC-stage lookup address
//   ld_da_cb_*              : DA-stage fill qualifiers
//   lsu_dcache_ld_xx_gwen, dcache_idx : dcache write for index invalidation
//   cb_ld_dc_addr_hit       : combinational DC lookup hit
//   cb_ld_da_data_vld/rd_sel: DA hit valid and registered read select
//   cb_data_wen             : data array write enables
//   cb_entry_vld / cb_idle  : per-entry VALID, no entry PEND
module ct_lsu_cb_ctrl
  import ct_lsu_cb_ctrl_pkg::*;
#(
  parameter int ENTRY_NUM = 2,
  parameter int TAG_W     = CB_TAG_W
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 cp0_lsu_dcache_en,
  input  logic                 cp0_lsu_cb_aclr_dis,
  input  logic                 cp0_lsu_no_op_req,
  input  logic                 icc_idle,
  input  logic                 ld_dc_cb_addr_create_vld,
  input  logic [TAG_W-1:0]     ld_dc_cb_addr_tto4,
  input  logic [TAG_W+3:0]     ld_dc_addr1,
  input  logic                 ld_da_cb_data_vld,
  input  logic                 ld_da_cb_ld_inst_vld,
  input  logic                 ld_da_cb_ecc_cancel,
  input  logic                 lsu_dcache_ld_xx_gwen,
  input  logic [8:0]           dcache_idx,
  output logic                 cb_ld_dc_addr_hit,
  output logic                 cb_ld_da_data_vld,
  output logic [ENTRY_NUM-1:0] cb_ld_da_rd_sel,
  output logic [ENTRY_NUM-1:0] cb_data_wen,
  output logic [ENTRY_NUM-1:0] cb_entry_vld,
  output logic                 cb_idle
);

  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  logic                 flush, fill, alloc_vld, idle_found, rr_found;
  logic [ENTRY_NUM-1:0] ent_vld, ent_pend, dc_hit, tag_match, inv, alloc_vec;
  logic [ENTRY_NUM-1:0] rd_sel_q, rd_sel_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d, vic_idx, rr_idx;
  logic [PTR_W:0]       rr_sum;

  // The fill qualifier is data_vld alone; inst_vld adds nothing beyond it.
  logic unused_ok;
  assign unused_ok = ^{ld_da_cb_ld_inst_vld, dcache_idx[8], ld_dc_addr1[3:0]};

  assign flush = ~cp0_lsu_dcache_en | cp0_lsu_cb_aclr_dis | cp0_lsu_no_op_req | ~icc_idle;
  assign fill  = ld_da_cb_data_vld & ~ld_da_cb_ecc_cancel;

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
    ct_lsu_cb_entry #(.TAG_W(TAG_W)) u_ent (
      .clk       (forever_cpuclk),
      .rst_n     (cpurst_b),
      .flush     (flush),
      .alloc     (alloc_vec[i]),
      .alloc_tag (ld_dc_cb_addr_tto4),
      .fill      (fill),
      .gwen      (lsu_dcache_ld_xx_gwen),
      .dc_idx    (dcache_idx[7:0]),
      .lkup_tag  (ld_dc_addr1[TAG_W+3:4]),
      .vld       (ent_vld[i]),
      .pend      (ent_pend[i]),
      .dc_hit    (dc_hit[i]),
      .tag_match (tag_match[i]),
      .inv       (inv[i]),
      .wen       (cb_data_wen[i])
    );
  end

  // Victim: lowest IDLE entry, else round-robin from rr_ptr skipping PEND
  // entries (a PEND entry is still resolving its fill this cycle).
  always_comb begin
    idle_found = 1'b0;
    rr_found   = 1'b0;
    vic_idx    = '0;
    rr_sum     = '0;
    rr_idx     = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!idle_found && !ent_vld[i] && !ent_pend[i]) begin
        idle_found = 1'b1;
        vic_idx    = PTR_W'(i);
      end
    end
    if (!idle_found) begin
      for (int k = 0; k < ENTRY_NUM; k++) begin
        rr_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (rr_sum >= (PTR_W+1)'(ENTRY_NUM)) rr_sum = rr_sum - (PTR_W+1)'(ENTRY_NUM);
        rr_idx = rr_sum[PTR_W-1:0];
        if (!rr_found && !ent_pend[rr_idx]) begin
          rr_found = 1'b1;
          vic_idx  = rr_idx;
        end
      end
    end
  end

  // Duplicate tags never allocate, which keeps lookup hits one-hot.
  assign alloc_vld = ld_dc_cb_addr_create_vld & ~flush & ~(|tag_match) & (idle_found | rr_found);

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) alloc_vec[i] = alloc_vld & (vic_idx == PTR_W'(i));
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (alloc_vld && !idle_found)
      rr_ptr_d = (vic_idx == PTR_W'(ENTRY_NUM-1)) ? '0 : vic_idx + PTR_W'(1);
  end

  assign rd_sel_d = dc_hit;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_ptr_q <= '0;
      rd_sel_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  assign cb_ld_dc_addr_hit = |dc_hit;
  assign cb_ld_da_rd_sel   = rd_sel_q;
  assign cb_ld_da_data_vld = ~flush & (|(rd_sel_q & ent_vld & ~inv));
  assign cb_entry_vld      = ent_vld;
  assign cb_idle           = ~(|ent_pend);

endmodule

// File: tb/tb_ct_lsu_cb_ctrl.sv
module tb_ct_lsu_cb_ctrl;
  localparam int N = 2;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst_b;
  logic          cp0_lsu_dcache_en, cp0_lsu_cb_aclr_dis, cp0_lsu_no_op_req, icc_idle;
  logic          ld_dc_cb_addr_create_vld;
  logic [35:0]   ld_dc_cb_addr_tto4;
  logic [39:0]   ld_dc_addr1;
  logic          ld_da_cb_data_vld, ld_da_cb_ld_inst_vld, ld_da_cb_ecc_cancel;
  logic          lsu_dcache_ld_xx_gwen;
  logic [8:0]    dcache_idx;
  logic          cb_ld_dc_addr_hit, cb_ld_da_data_vld, cb_idle;
  logic [N-1:0]  cb_ld_da_rd_sel, cb_data_wen, cb_entry_vld;

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_lsu_cb_ctrl #(.ENTRY_NUM(N), .TAG_W(36)) dut (
    .forever_cpuclk           (forever_cpuclk),
    .cpurst_b                 (cpurst_b),
    .cp0_lsu_dcache_en        (cp0_lsu_dcache_en),
    .cp0_lsu_cb_aclr_dis      (cp0_lsu_cb_aclr_dis),
    .cp0_lsu_no_op_req        (cp0_lsu_no_op_req),
    .icc_idle                 (icc_idle),
    .ld_dc_cb_addr_create_vld (ld_dc_cb_addr_create_vld),
    .ld_dc_cb_addr_tto4       (ld_dc_cb_addr_tto4),
    .ld_dc_addr1              (ld_dc_addr1),
    .ld_da_cb_data_vld        (ld_da_cb_data_vld),
    .ld_da_cb_ld_inst_vld     (ld_da_cb_ld_inst_vld),
    .ld_da_cb_ecc_cancel      (ld_da_cb_ecc_cancel),
    .lsu_dcache_ld_xx_gwen    (lsu_dcache_ld_xx_gwen),
    .dcache_idx               (dcache_idx),
    .cb_ld_dc_addr_hit        (cb_ld_dc_addr_hit),
    .cb_ld_da_data_vld        (cb_ld_da_data_vld),
    .cb_ld_da_rd_sel          (cb_ld_da_rd_sel),
    .cb_data_wen              (cb_data_wen),
    .cb_entry_vld             (cb_entry_vld),
    .cb_idle                  (cb_idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 = IDLE, 1 = PEND, 2 = VALID.
  int          m_st[N];
  logic [35:0] m_tag[N];
  int          m_rr;
  logic [N-1:0] m_rdsel, m_inv, m_hitv;
  bit          m_flush;
  logic        e_hit, e_dvld, e_idle;
  logic [N-1:0] e_wen, e_evld;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_st[i] = 0; m_tag[i] = '0; end
    m_rr = 0;
    m_rdsel = '0;
  endtask

  task automatic model_eval();
    m_flush = !cp0_lsu_dcache_en || cp0_lsu_cb_aclr_dis || cp0_lsu_no_op_req || !icc_idle;
    e_hit = 0; e_dvld = 0; e_idle = 1; e_wen = '0; e_evld = '0;
    for (int i = 0; i < N; i++) begin
      m_inv[i]  = lsu_dcache_ld_xx_gwen && m_st[i] != 0 && m_tag[i][7:0] == dcache_idx[7:0];
      m_hitv[i] = m_st[i] == 2 && m_tag[i] == ld_dc_addr1[39:4];
      e_evld[i] = m_st[i] == 2;
      e_wen[i]  = m_st[i] == 1 && ld_da_cb_data_vld && !ld_da_cb_ecc_cancel && !m_flush && !m_inv[i];
      if (m_hitv[i]) e_hit = 1;
      if (m_st[i] == 1) e_idle = 0;
      if (m_rdsel[i] && m_st[i] == 2 && !m_inv[i] && !m_flush) e_dvld = 1;
    end
  endtask

  task automatic model_update();
    int v;
    bit dup;
    model_eval();
    v = -1; dup = 0;
    if (ld_dc_cb_addr_create_vld && !m_flush) begin
      for (int i = 0; i < N; i++) if (m_st[i] != 0 && m_tag[i] == ld_dc_cb_addr_tto4) dup = 1;
      if (!dup) begin
        for (int i = 0; i < N; i++) if (v < 0 && m_st[i] == 0) v = i;
        if (v < 0)
          for (int k = 0; k < N; k++)
            if (v < 0 && m_st[(m_rr + k) % N] != 1) begin
              v = (m_rr + k) % N;
              m_rr = (v + 1) % N;
            end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_flush) m_st[i] = 0;
      else if (i == v) begin m_st[i] = 1; m_tag[i] = ld_dc_cb_addr_tto4; end
      else if (m_st[i] == 1) m_st[i] = e_wen[i] ? 2 : 0;
      else if (m_st[i] == 2 && m_inv[i]) m_st[i] = 0;
    end
    m_rdsel = m_hitv;
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    if (cpurst_b) model_update(); else model_reset();
    #1;
  endtask

  task automatic idle_in();
    cp0_lsu_dcache_en = 1; cp0_lsu_cb_aclr_dis = 0; cp0_lsu_no_op_req = 0; icc_idle = 1;
    ld_dc_cb_addr_create_vld = 0; ld_dc_cb_addr_tto4 = '0; ld_dc_addr1 = '0;
    ld_da_cb_data_vld = 0; ld_da_cb_ld_inst_vld = 0; ld_da_cb_ecc_cancel = 0;
    lsu_dcache_ld_xx_gwen = 0; dcache_idx = '0;
  endtask

  task automatic do_reset();
    idle_in();
    cpurst_b = 0;
    model_reset();
    repeat (2) @(posedge forever_cpuclk);
    #1 cpurst_b = 1;
  endtask

  task automatic create(input logic [35:0] t);
    ld_dc_cb_addr_create_vld = 1; ld_dc_cb_addr_tto4 = t;
  endtask

  task automatic test_reset();
    cpurst_b = 0;
    model_reset();
    create(36'h123456789); ld_dc_addr1 = 40'h1234567890; ld_da_cb_data_vld = 1;
    #3;
    n_cmp++; if (cb_entry_vld !== 2'b00) begin n_err++; $display("FAIL reset_vld got %b want 00", cb_entry_vld); end
    n_cmp++; if (cb_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b want 1", cb_idle); end
    n_cmp++; if ({cb_ld_dc_addr_hit, cb_ld_da_data_vld, cb_ld_da_rd_sel, cb_data_wen} !== '0) begin
      n_err++; $display("FAIL reset_outs got %b%b %b %b want all 0", cb_ld_dc_addr_hit, cb_ld_da_data_vld, cb_ld_da_rd_sel, cb_data_wen); end
  endtask

  task automatic test_fill_hit();
    do_reset();
    create(36'h123456789); #1; tick();
    ld_dc_cb_addr_create_vld = 0; ld_da_cb_data_vld = 1; ld_da_cb_ld_inst_vld = 1; #1;
    n_cmp++; if (cb_data_wen !== 2'b01) begin n_err++; $display("FAIL fill_wen got %b want 01", cb_data_wen); end
    n_cmp++; if (cb_idle !== 1'b0) begin n_err++; $display("FAIL fill_pend_idle got %b want 0", cb_idle); end
    tick();
    ld_da_cb_data_vld = 0; ld_da_cb_ld_inst_vld = 0; ld_dc_addr1 = 40'h1234567890; #1;
    n_cmp++; if (cb_entry_vld !== 2'b01) begin n_err++; $display("FAIL fill_vld got %b want 01", cb_entry_vld); end
    n_cmp++; if (cb_ld_dc_addr_hit !== 1'b1) begin n_err++; $display("FAIL fill_hit got %b want 1", cb_ld_dc_addr_hit); end
    tick();
    ld_dc_addr1 = '0; #1;
    n_cmp++; if (cb_ld_da_data_vld !== 1'b1 || cb_ld_da_rd_sel !== 2'b01) begin
      n_err++; $display("FAIL fill_da got dvld=%b sel=%b want 1 01", cb_ld_da_data_vld, cb_ld_da_rd_sel); end
  endtask

  task automatic test_fill_abort(input bit use_ecc);
    do_reset();
    create(36'h0F00D0042); #1; tick();
    ld_dc_cb_addr_create_vld = 0; ld_da_cb_ld_inst_vld = 1;
    ld_da_cb_data_vld = use_ecc; ld_da_cb_ecc_cancel = use_ecc; #1;
    n_cmp++; if (cb_data_wen !== 2'b00) begin n_err++; $display("FAIL abort_wen ecc=%0d got %b want 00", use_ecc, cb_data_wen); end
    tick();
    idle_in(); #1;
    n_cmp++; if (cb_entry_vld !== 2'b00 || cb_idle !== 1'b1) begin
      n_err++; $display("FAIL abort_state ecc=%0d got vld=%b idle=%b want 00 1", use_ecc, cb_entry_vld, cb_idle); end
  endtask

  task automatic test_replace();
    do_reset();
    create(36'h111111101); #1; tick();
    create(36'h222222202); ld_da_cb_data_vld = 1; #1; tick();
    ld_dc_cb_addr_create_vld = 0; #1;
    n_cmp++; if (cb_data_wen !== 2'b10) begin n_err++; $display("FAIL repl_b_wen got %b want 10", cb_data_wen); end
    tick();
    ld_da_cb_data_vld = 0; create(36'h333333303); #1;
    n_cmp++; if (cb_entry_vld !== 2'b11) begin n_err++; $display("FAIL repl_full got %b want 11", cb_entry_vld); end
    tick();
    create(36'h444444404); ld_da_cb_data_vld = 1; #1;
    n_cmp++; if (cb_data_wen !== 2'b01) begin n_err++; $display("FAIL repl_c_wen got %b want 01", cb_data_wen); end
    tick();
    ld_dc_cb_addr_create_vld = 0; #1;
    n_cmp++; if (cb_data_wen !== 2'b10) begin n_err++; $display("FAIL repl_d_wen got %b want 10", cb_data_wen); end
    tick();
    ld_da_cb_data_vld = 0; ld_dc_addr1 = {36'h333333303, 4'h7}; #1;
    n_cmp++; if (cb_ld_dc_addr_hit !== 1'b1) begin n_err++; $display("FAIL repl_c_hit got %b want 1", cb_ld_dc_addr_hit); end
    ld_dc_addr1 = {36'h111111101, 4'h0}; #1;
    n_cmp++; if (cb_ld_dc_addr_hit !== 1'b0) begin n_err++; $display("FAIL repl_a_gone got %b want 0", cb_ld_dc_addr_hit); end
    tick();
  endtask

  task automatic test_inv();
    do_reset();
    create(36'hABCDEF05A); #1; tick();
    ld_dc_cb_addr_create_vld = 0; ld_da_cb_data_vld = 1; #1; tick();
    ld_da_cb_data_vld = 0; ld_dc_addr1 = {36'hABCDEF05A, 4'h0};
    lsu_dcache_ld_xx_gwen = 1; dcache_idx = 9'h15B; #1;
    n_cmp++; if (cb_ld_dc_addr_hit !== 1'b1) begin n_err++; $display("FAIL inv_pre_hit got %b want 1", cb_ld_dc_addr_hit); end
    tick();
    ld_dc_addr1 = '0; dcache_idx = 9'h15A; #1;
    n_cmp++; if (cb_ld_da_data_vld !== 1'b0 || cb_ld_da_rd_sel !== 2'b01) begin
      n_err++; $display("FAIL inv_da got dvld=%b sel=%b want 0 01", cb_ld_da_data_vld, cb_ld_da_rd_sel); end
    tick();
    lsu_dcache_ld_xx_gwen = 0; #1;
    n_cmp++; if (cb_entry_vld !== 2'b00) begin n_err++; $display("FAIL inv_state got %b want 00", cb_entry_vld); end
  endtask

  task automatic test_flush(input int src);
    do_reset();
    create(36'h0000A0001); #1; tick();
    create(36'h0000B0002); ld_da_cb_data_vld = 1; #1; tick();
    ld_dc_cb_addr_create_vld = 0; ld_dc_addr1 = {36'h0000A0001, 4'h0}; #1; tick();
    if (src == 0) icc_idle = 0; else cp0_lsu_cb_aclr_dis = 1;
    create(36'h0000C0003); ld_da_cb_data_vld = 1; #1;
    n_cmp++; if (cb_ld_da_data_vld !== 1'b0 || cb_data_wen !== 2'b00) begin
      n_err++; $display("FAIL flush%0d_cycle got dvld=%b wen=%b want 0 00", src, cb_ld_da_data_vld, cb_data_wen); end
    tick();
    icc_idle = 1; cp0_lsu_cb_aclr_dis = 0; ld_dc_cb_addr_create_vld = 0; #1;
    n_cmp++; if (cb_entry_vld !== 2'b00 || cb_data_wen !== 2'b00 || cb_idle !== 1'b1) begin
      n_err++; $display("FAIL flush%0d_after got vld=%b wen=%b idle=%b want 00 00 1", src, cb_entry_vld, cb_data_wen, cb_idle); end
    n_cmp++; if (cb_ld_da_data_vld !== 1'b0) begin n_err++; $display("FAIL flush%0d_da got %b want 0", src, cb_ld_da_data_vld); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    create(36'h0AAAA0011); #1; tick();
    ld_da_cb_data_vld = 1; #1;
    n_cmp++; if (cb_data_wen !== 2'b01) begin n_err++; $display("FAIL b2b_same_wen got %b want 01", cb_data_wen); end
    tick();
    ld_dc_cb_addr_create_vld = 0; #1;
    n_cmp++; if (cb_data_wen !== 2'b00 || cb_entry_vld !== 2'b01) begin
      n_err++; $display("FAIL b2b_same_single got wen=%b vld=%b want 00 01", cb_data_wen, cb_entry_vld); end
    tick();
    do_reset();
    create(36'h0AAAA0011); #1; tick();
    create(36'h0BBBB0022); ld_da_cb_data_vld = 1; #1; tick();
    ld_dc_cb_addr_create_vld = 0; #1;
    n_cmp++; if (cb_data_wen !== 2'b10) begin n_err++; $display("FAIL b2b_dist_wen got %b want 10", cb_data_wen); end
    tick();
    // Steer rr_ptr onto entry 1 and make entry 1 PEND via the IDLE path.
    ld_da_cb_data_vld = 0; create(36'h0CCCC0033); #1; tick();
    ld_dc_cb_addr_create_vld = 0; ld_da_cb_data_vld = 1; #1; tick();
    ld_da_cb_data_vld = 0; lsu_dcache_ld_xx_gwen = 1; dcache_idx = 9'h022; #1; tick();
    lsu_dcache_ld_xx_gwen = 0; create(36'h0DDDD0044); #1;
    n_cmp++; if (cb_entry_vld !== 2'b01) begin n_err++; $display("FAIL b2b_inv1 got %b want 01", cb_entry_vld); end
    tick();
    create(36'h0EEEE0055); #1; tick();
    ld_dc_cb_addr_create_vld = 0; ld_da_cb_data_vld = 1; #1;
    n_cmp++; if (cb_data_wen !== 2'b01) begin n_err++; $display("FAIL b2b_skip_pend got %b want 01", cb_data_wen); end
    tick();
    // Reset in the middle of a fill.
    do_reset();
    create(36'h0AAAA0011); #1; tick();
    ld_dc_cb_addr_create_vld = 0; ld_da_cb_data_vld = 1; cpurst_b = 0; #1;
    n_cmp++; if (cb_data_wen !== 2'b00 || cb_idle !== 1'b1 || cb_entry_vld !== 2'b00) begin
      n_err++; $display("FAIL midrst got wen=%b idle=%b vld=%b want 00 1 00", cb_data_wen, cb_idle, cb_entry_vld); end
    tick();
    cpurst_b = 1;
  endtask

  task automatic test_random();
    logic [35:0] pool[6];
    for (int k = 0; k < 6; k++) pool[k] = {28'($urandom), 8'(8'h30 + k % 4)};
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cp0_lsu_dcache_en        = $urandom_range(0, 31) != 0;
      cp0_lsu_cb_aclr_dis      = $urandom_range(0, 47) == 0;
      cp0_lsu_no_op_req        = $urandom_range(0, 47) == 0;
      icc_idle                 = $urandom_range(0, 31) != 0;
      ld_dc_cb_addr_create_vld = 1'($urandom);
      ld_dc_cb_addr_tto4       = pool[$urandom_range(0, 5)];
      ld_dc_addr1              = {pool[$urandom_range(0, 5)], 4'($urandom)};
      ld_da_cb_data_vld        = $urandom_range(0, 3) != 0;
      ld_da_cb_ld_inst_vld     = 1'($urandom);
      ld_da_cb_ecc_cancel      = $urandom_range(0, 7) == 0;
      lsu_dcache_ld_xx_gwen    = $urandom_range(0, 7) == 0;
      dcache_idx               = {1'($urandom), pool[$urandom_range(0, 5)][7:0]};
      #1;
      model_eval();
      n_cmp++;
      if ({cb_ld_dc_addr_hit, cb_ld_da_data_vld, cb_ld_da_rd_sel, cb_data_wen, cb_entry_vld, cb_idle} !==
          {e_hit, e_dvld, m_rdsel, e_wen, e_evld, e_idle}) begin
        n_err++;
        $display("FAIL rand c=%0d got hit=%b dvld=%b sel=%b wen=%b vld=%b idle=%b want %b %b %b %b %b %b", c,
                 cb_ld_dc_addr_hit, cb_ld_da_data_vld, cb_ld_da_rd_sel, cb_data_wen, cb_entry_vld, cb_idle,
                 e_hit, e_dvld, m_rdsel, e_wen, e_evld, e_idle);
      end
      tick();
    end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_fill_hit();
    test_fill_abort(0);
    test_fill_abort(1);
    test_replace();
    test_inv();
    test_flush(0);
    test_flush(1);
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ct_lsu_cb_ctrl.md
Name: ct_lsu_cb_ctrl

Overview:
- Multi-entry controller for the LSU load cache buffer (CB).
- Owns per-entry state, physical-address tags and the replacement pointer; the 128-bit data array stays external and is steered through one-hot write and read vectors.
- Performs the ld DC-stage tag lookup, sequences allocation from DC stage to data fill in DA stage, and invalidates entries on dcache writes or global flush conditions.

Parameters:
- ENTRY_NUM, 2, number of CB entries (2..4).
- TAG_W, 36, tag width: PA[39:4].

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  reset; asynchronous, active-low.
- cp0_lsu_dcache_en  in  1  dcache enable; 0 flushes.
- cp0_lsu_cb_aclr_dis  in  1  CB disable; 1 flushes and blocks allocation.
- cp0_lsu_no_op_req  in  1  flush request.
- icc_idle  in  1  cache-maintenance idle; 0 flushes.
- ld_dc_cb_addr_create_vld  in  1  DC-stage allocation request.
- ld_dc_cb_addr_tto4  in  36  tag to allocate.
- ld_dc_addr1  in  40  DC-stage lookup address.
- ld_da_cb_data_vld  in  1  DA-stage fill data valid.
- ld_da_cb_ld_inst_vld  in  1  DA-stage load valid.
- ld_da_cb_ecc_cancel  in  1  DA-stage ECC cancel.
- lsu_dcache_ld_xx_gwen  in  1  dcache write in progress.
- dcache_idx  in  9  dcache write index; only bits [7:0] used.
- cb_ld_dc_addr_hit  out  1  combinational DC lookup hit.
- cb_ld_da_data_vld  out  1  registered DA hit valid.
- cb_ld_da_rd_sel  out  ENTRY_NUM  registered one-hot data read select.
- cb_data_wen  out  ENTRY_NUM  one-hot data array write enable.
- cb_entry_vld  out  ENTRY_NUM  per-entry VALID state.
- cb_idle  out  1  no entry in PEND state.

Behaviour:
- Reset: all entries IDLE, tags 0, rr_ptr = entry 0. All outputs 0, except cb_idle = 1.
- Per-entry FSM states: IDLE, PEND, VALID.
- flush = !cp0_lsu_dcache_en | cp0_lsu_cb_aclr_dis | cp0_lsu_no_op_req | !icc_idle.
- flush:
  - Next cycle all entries are IDLE.
  - No allocation, no cb_data_wen and no cb_ld_da_data_vld in a flush cycle.
  - Flush has highest priority.
- inv[i] = lsu_dcache_ld_xx_gwen & (tag[i][7:0] == dcache_idx[7:0]).
  - Tag bits [7:0] are PA[11:4].
  - inv[i] applies to PEND and VALID entries: entry goes to IDLE next cycle.
  - inv[i] beats a fill to entry i: cb_data_wen[i] = 0.
- Lookup:
  - dc_hit[i] = (state[i] == VALID) & (tag[i] == ld_dc_addr1[39:4]).
  - cb_ld_dc_addr_hit = |dc_hit.
  - At most one entry hits; allocation guarantees this.
- Allocation, when create_vld & !flush:
  - If ld_dc_cb_addr_tto4 matches any VALID or PEND tag, nothing is allocated.
  - Otherwise the victim is the lowest-index IDLE entry.
  - If no entry is IDLE, the victim is rr_ptr, advanced past any PEND entry; rr_ptr then increments modulo ENTRY_NUM.
  - Victim: tag captured, state goes to PEND next cycle.
  - If every entry is PEND (ENTRY_NUM = 1 only), the request is dropped.
- PEND resolution happens in the following cycle (DA stage), so PEND always lasts exactly one cycle:
  - If ld_da_cb_data_vld & !ld_da_cb_ecc_cancel & !flush & !inv: cb_data_wen[i] = 1 and the entry goes to VALID.
  - Otherwise the entry goes to IDLE. This covers inst_vld without data, no inst, ecc_cancel, flush and inv.
- Back-to-back creates: a PEND entry resolving in cycle t+1 is excluded from victim selection for a new create in t+1.
- DA read path:
  - cb_ld_da_rd_sel <= dc_hit, registered every cycle.
  - cb_ld_da_data_vld = (|rd_sel_q) & !flush & !(inv & rd_sel_q any) & selected entry still VALID.
- cb_idle = no entry in PEND.
- Reset mid-operation: every entry returns to IDLE and all outputs return to reset values.

Decomposition:
- Shared package constants: CB_ST_IDLE = 2'd0, CB_ST_PEND = 2'd1, CB_ST_VALID = 2'd2; CB_TAG_W = 36.
- Sub-module ct_lsu_cb_entry, instantiated ENTRY_NUM times. It holds state, tag, the tag compare, the idx compare and the FSM.
- The top level holds victim select, rr_ptr, flush and the read-select register.

Test Plan:
1. Fill and hit: create tag 0x123456789 at t0, data_vld at t1 → cb_data_wen = 01 at t1, cb_entry_vld = 01 at t2. Lookup of addr1 = 0x1234567890 at t2 → cb_ld_dc_addr_hit = 1; cb_ld_da_data_vld = 1 and rd_sel = 01 at t3.
2. Fill aborted: create at t0; at t1 ld_inst_vld = 1 and data_vld = 0 → no wen, entry IDLE at t2. Repeat with data_vld = 1 and ecc_cancel = 1 → same result.
3. Replacement: fill tags A, B (entries 0, 1); create C → entry 0 (rr = 0) replaced, rr = 1. Create D → entry 1 replaced.
4. Index invalidate: entry 0 VALID with tag[7:0] = 0x5A; gwen = 1, dcache_idx = 0x15A → entry 0 IDLE next cycle; a DA hit in the same cycle gives cb_ld_da_data_vld = 0.
5. Flush: both entries VALID, icc_idle = 0 for one cycle → both IDLE. A concurrent create is dropped with no wen. Repeat with cp0_lsu_cb_aclr_dis = 1.
6. Back-to-back creates of the same tag at t0 and t1 → single allocation. Distinct tags → two entries, no PEND entry chosen as victim. Assert cpurst_b low at t1 → all entries IDLE.
